// File: rtl/pwm_cmd_ctrl.sv
// ASCII command sequencer: pops bytes from the uart_rx FIFO, parses
// "<op><ch><hhhh>\n" lines and commits period/duty/enable to one PWM channel.
module pwm_cmd_ctrl #(
   parameter int unsigned NumChannels = 4,
   parameter int unsigned ValueWidth  = 16
) (
   input  logic                              clk_50mhz,
   input  logic                              rst_n,
   input  logic                              fifo_empty,
   input  logic [7:0]                        fifo_data,
   output logic                              fifo_read,
   output logic [NumChannels*ValueWidth-1:0] period,
   output logic [NumChannels*ValueWidth-1:0] duty,
   output logic [NumChannels-1:0]            ch_enable,
   output logic                              cmd_done,
   output logic                              cmd_err
);

   localparam int unsigned RegWidth = NumChannels * ValueWidth;
   localparam logic [7:0]  ChrLf    = 8'h0A;
   localparam logic [7:0]  ChrCr    = 8'h0D;
   localparam logic [7:0]  ChrP     = 8'h50;
   localparam logic [7:0]  ChrD     = 8'h44;
   localparam logic [7:0]  ChrE     = 8'h45;
   localparam logic [7:0]  ChrZero  = 8'h30;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PARSE} state_t;
   typedef enum logic [2:0] {
      PH_OP, PH_CH, PH_H3, PH_H2, PH_H1, PH_H0, PH_TERM, PH_DISCARD
   } phase_t;
   typedef enum logic [1:0] {OPC_P, OPC_D, OPC_E} opc_t;

   state_t                 state_q, state_d;
   phase_t                 phase_q, phase_d;
   opc_t                   opc_q, opc_d;
   logic [3:0]             ch_q, ch_d;
   logic [ValueWidth-1:0]  stage_q, stage_d;
   logic [7:0]             byte_q, byte_d;
   logic [RegWidth-1:0]    period_d, duty_d;
   logic [NumChannels-1:0] enable_d;
   logic                   fifo_read_d, done_d, err_d;
   logic                   parse_err;
   logic [4:0]             hex;
   logic [7:0]             ch_off;

   // {valid, nibble} for an ASCII hex digit, case-insensitive
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [4:0] r;
      r = '0;
      if (b >= 8'h30 && b <= 8'h39) begin
         r = {1'b1, b[3:0]};
      end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
         r = {1'b1, 4'(b[3:0] + 4'd9)};
      end
      return r;
   endfunction

   // Fetch FSM, parser and commit logic
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      opc_d       = opc_q;
      ch_d        = ch_q;
      stage_d     = stage_q;
      byte_d      = byte_q;
      period_d    = period;
      duty_d      = duty;
      enable_d    = ch_enable;
      done_d      = 1'b0;
      err_d       = 1'b0;
      parse_err   = 1'b0;
      hex         = hex_decode(byte_q);
      ch_off      = byte_q - ChrZero;

      unique case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            byte_d  = fifo_data;
            state_d = S_PARSE;
         end
         S_PARSE: begin
            state_d = S_IDLE;
            if (byte_q != ChrCr) begin
               unique case (phase_q)
                  PH_OP: begin
                     if (byte_q == ChrP) begin
                        opc_d = OPC_P; phase_d = PH_CH;
                     end else if (byte_q == ChrD) begin
                        opc_d = OPC_D; phase_d = PH_CH;
                     end else if (byte_q == ChrE) begin
                        opc_d = OPC_E; phase_d = PH_CH;
                     end else if (byte_q != ChrLf) begin
                        parse_err = 1'b1;
                     end
                  end
                  PH_CH: begin
                     if (ch_off < 8'(NumChannels)) begin
                        ch_d    = 4'(ch_off);
                        phase_d = PH_H3;
                     end else begin
                        parse_err = 1'b1;
                     end
                  end
                  PH_H3, PH_H2, PH_H1, PH_H0: begin
                     if (hex[4]) begin
                        stage_d = {stage_q[ValueWidth-5:0], hex[3:0]};
                        phase_d = phase_t'(phase_q + 3'd1);
                     end else begin
                        parse_err = 1'b1;
                     end
                  end
                  PH_TERM: begin
                     if (byte_q == ChrLf) begin
                        done_d  = 1'b1;
                        phase_d = PH_OP;
                        for (int unsigned c = 0; c < NumChannels; c++) begin
                           if (ch_q == 4'(c)) begin
                              if (opc_q == OPC_P) begin
                                 period_d[c*ValueWidth +: ValueWidth] = stage_q;
                              end else if (opc_q == OPC_D) begin
                                 duty_d[c*ValueWidth +: ValueWidth] = stage_q;
                              end else begin
                                 enable_d[c] = stage_q[0];
                              end
                           end
                        end
                     end else begin
                        parse_err = 1'b1;
                     end
                  end
                  PH_DISCARD: if (byte_q == ChrLf) phase_d = PH_OP;
               endcase
               // A rejected LF already ends the line, so no discard is needed
               if (parse_err) begin
                  err_d   = 1'b1;
                  stage_d = '0;
                  phase_d = (byte_q == ChrLf) ? PH_OP : PH_DISCARD;
               end
            end
         end
      endcase

      fifo_read_d = (state_d == S_FETCH);
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_OP;
         opc_q     <= OPC_P;
         ch_q      <= '0;
         stage_q   <= '0;
         byte_q    <= '0;
         period    <= {RegWidth{1'b1}};
         duty      <= '0;
         ch_enable <= '0;
         fifo_read <= 1'b0;
         cmd_done  <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         opc_q     <= opc_d;
         ch_q      <= ch_d;
         stage_q   <= stage_d;
         byte_q    <= byte_d;
         period    <= period_d;
         duty      <= duty_d;
         ch_enable <= enable_d;
         fifo_read <= fifo_read_d;
         cmd_done  <= done_d;
         cmd_err   <= err_d;
      end
   end

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Bench for pwm_cmd_ctrl: FIFO model, directed command lines plus random lines,
// checked against a line-buffer reference model of the command grammar.
module tb_pwm_cmd_ctrl;

   localparam int unsigned NCH = 4;
   localparam int unsigned VW  = 16;

   logic               clk_50mhz = 1'b0;
   logic               rst_n;
   logic               fifo_empty;
   logic [7:0]         fifo_data;
   logic               fifo_read;
   logic [NCH*VW-1:0]  period;
   logic [NCH*VW-1:0]  duty;
   logic [NCH-1:0]     ch_enable;
   logic               cmd_done;
   logic               cmd_err;

   always #10 clk_50mhz = ~clk_50mhz;

   pwm_cmd_ctrl #(.NumChannels(NCH), .ValueWidth(VW)) dut (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_read (fifo_read),
      .period    (period),
      .duty      (duty),
      .ch_enable (ch_enable),
      .cmd_done  (cmd_done),
      .cmd_err   (cmd_err)
   );

   logic [7:0]  fifo_q[$];
   logic [7:0]  inflight[$];
   int          n_pass = 0, n_fail = 0, n_total = 0;
   int          lat = 0, rd_gap = 100, done_cnt = 0, err_cnt = 0;

   // reference model: the current line's accepted characters and register images
   logic [7:0]  line[$];
   bit          bad;
   logic [15:0] m_per[NCH];
   logic [15:0] m_duty[NCH];
   logic [NCH-1:0] m_en;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] hexval(input logic [7:0] b);
      string digits = "0123456789abcdef";
      logic [7:0] lc;
      lc = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
      for (int i = 0; i < 16; i++) if (digits[i] == lc) return {1'b1, 4'(i)};
      return 5'd0;
   endfunction

   function automatic bit char_ok(input int pos, input logic [7:0] b);
      if (pos == 0) return (b == 8'h50 || b == 8'h44 || b == 8'h45);
      if (pos == 1) return (b >= 8'h30 && int'(b) < 8'h30 + NCH);
      return hexval(b)[4] == 1'b1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_per[c]  = 16'hFFFF;
         m_duty[c] = 16'h0000;
      end
      m_en = '0;
      line.delete();
      bad = 0;
   endtask

   // returns {done, err} for one consumed byte
   task automatic model_byte(input logic [7:0] b, output logic [1:0] pulse);
      int v, ch;
      pulse = 2'b00;
      if (b == 8'h0D) return;
      if (bad) begin
         if (b == 8'h0A) bad = 0;
         return;
      end
      if (b == 8'h0A) begin
         if (line.size() == 6) begin
            v = 0;
            for (int i = 2; i < 6; i++) v = v * 16 + int'(hexval(line[i])[3:0]);
            ch = int'(line[1]) - 48;
            if (line[0] == 8'h50)      m_per[ch]  = 16'(v);
            else if (line[0] == 8'h44) m_duty[ch] = 16'(v);
            else                       m_en[ch]   = 1'(v % 2);
            pulse = 2'b10;
         end else if (line.size() != 0) begin
            pulse = 2'b01;
         end
         line.delete();
         return;
      end
      if (line.size() < 6 && char_ok(line.size(), b)) begin
         line.push_back(b);
      end else begin
         line.delete();
         bad   = 1;
         pulse = 2'b01;
      end
   endtask

   function automatic logic [63:0] pk_per();
      logic [63:0] r = '0;
      for (int c = 0; c < NCH; c++) r[c*16 +: 16] = m_per[c];
      return r;
   endfunction

   function automatic logic [63:0] pk_duty();
      logic [63:0] r = '0;
      for (int c = 0; c < NCH; c++) r[c*16 +: 16] = m_duty[c];
      return r;
   endfunction

   // one clock: entered and left at a falling edge; serves the FIFO and checks outputs
   task automatic cycle();
      logic       rd, emp;
      logic [1:0] exp;
      bit         chk_now;
      chk_now = 0;
      rd  = fifo_read;
      emp = fifo_empty;
      if (rd) begin
         chk("rd_gap_ge4", 64'(rd_gap >= 4), 64'd1);
         chk("rd_while_empty", 64'(emp), 64'd0);
         rd_gap = 0;
      end
      @(posedge clk_50mhz);
      #1;
      rd_gap++;
      if (rd && fifo_q.size() > 0) begin
         fifo_data = fifo_q.pop_front();
         inflight.push_back(fifo_data);
         lat = 2;
      end else if (lat > 0) begin
         lat--;
         chk_now = (lat == 0);
      end
      fifo_empty = (fifo_q.size() == 0);
      exp = 2'b00;
      if (chk_now) model_byte(inflight.pop_front(), exp);
      chk("pulses", 64'({cmd_done, cmd_err}), 64'(exp));
      if (chk_now) begin
         chk("period", period, pk_per());
         chk("duty", duty, pk_duty());
         chk("ch_enable", 64'(ch_enable), 64'(m_en));
      end
      if (cmd_done) done_cnt++;
      if (cmd_err) err_cnt++;
      @(negedge clk_50mhz);
   endtask

   task automatic drain();
      int n = 0;
      while ((fifo_q.size() != 0 || lat != 0) && n < 3000) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 64'(n < 3000), 64'd1);
      repeat (2) cycle();
   endtask

   task automatic send_bytes(input logic [7:0] bs[$], input int max_gap);
      foreach (bs[i]) begin
         fifo_q.push_back(bs[i]);
         fifo_empty = 1'b0;
         repeat ($urandom_range(0, max_gap)) cycle();
      end
      drain();
   endtask

   task automatic send_str(input string s, input int max_gap);
      logic [7:0] b[$];
      for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
      send_bytes(b, max_gap);
   endtask

   function automatic logic [7:0] hexchr(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
   endfunction

   task automatic random_line();
      logic [7:0]  l[$];
      logic [7:0]  ops[3];
      logic [15:0] v;
      int          mode, pos;
      ops[0] = 8'h50; ops[1] = 8'h44; ops[2] = 8'h45;
      v = 16'($urandom);
      l.push_back(ops[$urandom_range(0, 2)]);
      l.push_back(8'h30 + 8'($urandom_range(0, NCH - 1)));
      for (int i = 3; i >= 0; i--) l.push_back(hexchr(v[i*4 +: 4], 1'($urandom_range(0, 1))));
      if ($urandom_range(0, 3) == 0) l.push_back(8'h0D);
      l.push_back(8'h0A);
      mode = $urandom_range(0, 3);
      pos  = $urandom_range(0, 5);
      if (mode == 2) l[pos] = 8'($urandom_range(0, 127));
      else if (mode == 3) l.delete(pos);
      send_bytes(l, 6);
   endtask

   int d0, e0, rd_cnt;

   initial begin
      rst_n      = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      model_reset();
      repeat (3) @(negedge clk_50mhz);
      chk("rst_fifo_read", 64'(fifo_read), 64'd0);
      chk("rst_cmd_done", 64'(cmd_done), 64'd0);
      chk("rst_cmd_err", 64'(cmd_err), 64'd0);
      chk("rst_period", period, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_duty", duty, 64'd0);
      chk("rst_enable", 64'(ch_enable), 64'd0);
      rst_n = 1'b1;
      repeat (3) cycle();

      d0 = done_cnt; e0 = err_cnt;
      send_str("D18000\n", 0);
      chk("d1_duty1", 64'(duty[31:16]), 64'h8000);
      chk("d1_duty_rest", duty, 64'h0000_0000_8000_0000);
      chk("d1_period", period, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("d1_done_cnt", 64'(done_cnt - d0), 64'd1);

      d0 = done_cnt; e0 = err_cnt;
      send_str("P003e8\r\n", 3);
      chk("p0_period0", 64'(period[15:0]), 64'h03E8);
      chk("p0_done_cnt", 64'(done_cnt - d0), 64'd1);
      chk("p0_err_cnt", 64'(err_cnt - e0), 64'd0);

      d0 = done_cnt;
      send_str("E20001\n", 2);
      chk("e2_on", 64'(ch_enable[2]), 64'd1);
      send_str("E20000\n", 2);
      chk("e2_off", 64'(ch_enable[2]), 64'd0);
      chk("e2_done_cnt", 64'(done_cnt - d0), 64'd2);

      d0 = done_cnt; e0 = err_cnt;
      send_str("X12\n", 1);
      chk("x_err_cnt", 64'(err_cnt - e0), 64'd1);
      chk("x_done_cnt", 64'(done_cnt - d0), 64'd0);
      send_str("D00010\n", 1);
      chk("x_duty0", 64'(duty[15:0]), 64'h0010);

      e0 = err_cnt;
      send_str("D90001\n", 0);
      chk("d9_err_cnt", 64'(err_cnt - e0), 64'd1);
      e0 = err_cnt;
      send_str("D012\n", 0);
      chk("short_err_cnt", 64'(err_cnt - e0), 64'd1);
      chk("short_duty0", 64'(duty[15:0]), 64'h0010);

      for (int i = 0; i < 40; i++) random_line();

      send_str("P312", 2);
      rst_n = 1'b0;
      #1;
      chk("arst_fifo_read", 64'(fifo_read), 64'd0);
      chk("arst_done_err", 64'({cmd_done, cmd_err}), 64'd0);
      chk("arst_period", period, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("arst_duty", duty, 64'd0);
      chk("arst_enable", 64'(ch_enable), 64'd0);
      model_reset();
      inflight.delete();
      lat = 0;
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();
      send_str("P3ABCD\n", 3);
      chk("rst_p3_period3", 64'(period[63:48]), 64'hABCD);

      rd_cnt = 0;
      repeat (100) begin
         rd_cnt += int'(fifo_read);
         cycle();
      end
      chk("idle_no_read", 64'(rd_cnt), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pwm_cmd_ctrl.md
# pwm_cmd_ctrl

Command sequencer between the `uart_rx` receive FIFO and the PWM channel bank. It drains received bytes one at a time and parses ASCII commands of the form opcode, channel digit, four hex digits and LF. Each valid command commits a period, duty or enable value to one PWM channel. Malformed lines are flagged and discarded up to the next LF, so a noisy host cannot corrupt channel configuration.

## Interface
- `NumChannels`, default 4: number of PWM channels; valid range 1..10, with channel digits '0'..NumChannels-1.
- `ValueWidth`, default 16: width of the period and duty registers; fixed at 4 hex digits, so it must be 16.
- `clk_50mhz`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `fifo_empty`  in  1  `uart_rx` FIFO empty flag.
- `fifo_data`  in  8  `uart_rx` FIFO read data; valid the cycle after `fifo_read`.
- `fifo_read`  out  1  single-cycle FIFO pop strobe.
- `period`  out  NumChannels*ValueWidth  per-channel period; channel c occupies bits [c*16 +: 16].
- `duty`  out  NumChannels*ValueWidth  per-channel duty, same packing as `period`.
- `ch_enable`  out  NumChannels  per-channel enable.
- `cmd_done`  out  1  one-cycle pulse when a command commits.
- `cmd_err`  out  1  one-cycle pulse when a line is rejected.

## Operation
- The fetch FSM has four states:
  - IDLE: go to FETCH when `fifo_empty` is 0.
  - FETCH: `fifo_read` is 1 for this cycle only; go to WAIT.
  - WAIT: register `fifo_data` into `byte_q`; go to PARSE.
  - PARSE: evaluate `byte_q` against the current parse phase; go to IDLE.
- Parse phases are OP, CH, H3, H2, H1, H0, TERM and DISCARD.
- OP phase:
  - 'P' (0x50), 'D' (0x44) or 'E' (0x45) latches the opcode and moves to CH.
  - LF (0x0A) stays in OP and raises no error (empty line).
  - Any other byte raises an error.
- CH phase: a digit below NumChannels latches the channel and moves to H3. Any other byte is an error.
- H3..H0 phases:
  - Hex digits 0-9, A-F and a-f are accepted; case is ignored.
  - Each digit shifts into a 16-bit staging register, MSB nibble first.
  - H0 moves to TERM.
- TERM phase: LF commits the command and moves to OP. Any other byte is an error.
- CR (0x0D) is ignored in every phase: no phase change and no error.
- Error handling:
  - `cmd_err` pulses and the staging register is discarded.
  - If the offending byte is LF, the phase goes to OP; otherwise it goes to DISCARD.
  - DISCARD drops every byte until LF, then goes to OP. Bytes dropped in DISCARD raise no further `cmd_err`.
- Commit:
  - 'P' writes `period[ch]`, 'D' writes `duty[ch]`, and 'E' writes `ch_enable[ch]` = staging bit 0. Bits 15:1 of an 'E' value are ignored.
  - The write and the `cmd_done` pulse happen together.
  - Registers change only on commit; a partial command never alters any output.
- No arithmetic checks are made: duty > period is legal and the PWM treats it as 100 %. Period 0 is legal.

## Timing
- Reset values:
  - `fifo_read`, `cmd_done`, `cmd_err` = 0.
  - All `period` = 0xFFFF, all `duty` = 0x0000, `ch_enable` = 0.
  - FSM in IDLE, phase OP.
- Reset is asynchronous. Asserting it mid-command abandons the partial line with no pulse, and parsing restarts in OP.
- Per byte: `fifo_empty` is seen low in IDLE at cycle N, `fifo_read` is high at N+1, data is captured at N+2, and PARSE runs at N+3.
- Outputs and pulses are registered and become visible at N+4.
- The minimum spacing between pops is 4 cycles. A UART byte takes about 4340 cycles, so the FIFO never backs up because of this block.
- `fifo_read` is never asserted while `fifo_empty` is 1, and never twice within 4 cycles.
- `cmd_done` and `cmd_err` are mutually exclusive and last exactly one cycle.
- An LF in TERM commits; an LF in any other non-OP phase errors. Both take effect in the same PARSE cycle.

## Test plan
- "D1" + "8000" + LF pushed into the FIFO, then the bench checks:
  - `duty[1]` = 0x8000 and `cmd_done` pulses once.
  - All other registers keep their reset values.
  - The gap between `fifo_read` pulses is at least 4 cycles.
- "P0" + "03e8" + CR + LF → `period[0]` = 0x03E8 (lower-case hex and CR are accepted); `cmd_done` pulses once and `cmd_err` stays 0.
- "E2" + "0001" + LF, then "E2" + "0000" + LF → `ch_enable[2]` rises, then falls; two `cmd_done` pulses.
- "X" + "12" + LF, followed by "D0" + "0010" + LF:
  - One `cmd_err` pulse, raised at the 'X' byte.
  - No register changes on the bad line.
  - `duty[0]` = 0x0010 after the second line.
- Two short lines:
  - "D9" + "0001" + LF with NumChannels = 4 → one `cmd_err` on '9'.
  - "D0" + "12" + LF → `cmd_err` on the LF, with `duty[0]` unchanged.
- Reset mid-line: assert `rst_n` = 0 after "P3" + "12" has been consumed. The bench checks:
  - All outputs return to their reset values immediately (asynchronously).
  - After release, "P3" + "ABCD" + LF sets `period[3]` = 0xABCD.
  - An empty FIFO held for 100 cycles produces no `fifo_read`.
